// File: rtl/vu_vxu_fu_imul_pipe.sv
// Elastic, tagged integer multiplier for the VXU lanes: full/half-width mul/mulh*,
// STAGES-deep valid/ready pipeline with bubble collapsing and synchronous kill.
module vu_vxu_fu_imul_pipe #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STAGES = 3,
  parameter int unsigned TAG_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             val,
  output logic             rdy,
  input  logic [3:0]       fn,
  input  logic [XLEN-1:0]  in0,
  input  logic [XLEN-1:0]  in1,
  input  logic [TAG_W-1:0] tag,
  input  logic             kill,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [XLEN-1:0]  out,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned H    = XLEN / 2;
  localparam int unsigned LAST = STAGES - 1;

  typedef enum logic [3:0] {
    FN_32    = 4'd0,
    FN_32H   = 4'd1,
    FN_32HU  = 4'd2,
    FN_32HSU = 4'd3,
    FN_64    = 4'd4,
    FN_64H   = 4'd5,
    FN_64HU  = 4'd6,
    FN_64HSU = 4'd7
  } fn_e;

  logic lhs_s, rhs_s, half, hi, known;

  always_comb begin
    lhs_s = 1'b0;
    rhs_s = 1'b0;
    half  = 1'b0;
    hi    = 1'b0;
    known = 1'b1;
    case (fn)
      FN_32:    half = 1'b1;
      FN_32H:   begin half = 1'b1; hi = 1'b1; lhs_s = 1'b1; rhs_s = 1'b1; end
      FN_32HU:  begin half = 1'b1; hi = 1'b1; end
      FN_32HSU: begin half = 1'b1; hi = 1'b1; lhs_s = 1'b1; end
      FN_64:    ;
      FN_64H:   begin hi = 1'b1; lhs_s = 1'b1; rhs_s = 1'b1; end
      FN_64HU:  hi = 1'b1;
      FN_64HSU: begin hi = 1'b1; lhs_s = 1'b1; end
      default:  known = 1'b0;
    endcase
  end

  logic signed [XLEN:0]     lhs, rhs;
  // Only the low 2*XLEN bits of the signed product are ever selected.
  logic signed [2*XLEN-1:0] prod;
  logic        [H-1:0]      res_half;
  logic        [XLEN-1:0]   res;

  always_comb begin
    if (half) begin
      lhs = {{(H+1){lhs_s & in0[H-1]}}, in0[H-1:0]};
      rhs = {{(H+1){rhs_s & in1[H-1]}}, in1[H-1:0]};
    end else begin
      lhs = {lhs_s & in0[XLEN-1], in0};
      rhs = {rhs_s & in1[XLEN-1], in1};
    end
    prod     = lhs * rhs;
    res_half = hi ? prod[2*H-1:H] : prod[H-1:0];
    if (!known)    res = '0;
    else if (half) res = {{H{res_half[H-1]}}, res_half};
    else           res = hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES:0]   free;
  logic [XLEN-1:0]   data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];

  // free[k] = ~v[k] | adv[k]; since adv[k] = v[k] & free[k+1] this folds to ~v[k] | free[k+1].
  always_comb begin
    free         = '0;
    free[STAGES] = out_rdy;
    for (int unsigned i = 0; i < STAGES; i++) begin
      free[LAST-i] = ~v_q[LAST-i] | free[LAST-i+1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
    end else if (kill) begin
      v_q <= '0;
    end else begin
      if (free[0]) v_q[0] <= val;
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (free[k]) v_q[k] <= v_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (free[0] && val) begin
      data_q[0] <= res;
      tag_q[0]  <= tag;
    end
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (free[k] && v_q[k-1]) begin
        data_q[k] <= data_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
    end
  end

  assign rdy     = free[0];
  assign out_val = v_q[LAST];
  assign out     = data_q[LAST];
  assign out_tag = tag_q[LAST];
  assign busy    = |v_q;

endmodule

// File: tb/tb_vu_vxu_fu_imul_pipe.sv
// Bench for vu_vxu_fu_imul_pipe: 64-bit/3-stage instance plus a 32-bit/1-stage instance.
module tb_vu_vxu_fu_imul_pipe;

  localparam int unsigned STG_A = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        a_val, a_rdy, a_kill, a_out_val, a_out_rdy, a_busy;
  logic [3:0]  a_fn;
  logic [63:0] a_in0, a_in1, a_out;
  logic [7:0]  a_tag, a_out_tag;

  logic        b_val, b_rdy, b_kill, b_out_val, b_out_rdy, b_busy;
  logic [3:0]  b_fn;
  logic [31:0] b_in0, b_in1, b_out;
  logic [7:0]  b_tag, b_out_tag;

  vu_vxu_fu_imul_pipe #(.XLEN(64), .STAGES(STG_A), .TAG_W(8)) dut_a (
    .clk(clk), .reset(reset), .val(a_val), .rdy(a_rdy), .fn(a_fn),
    .in0(a_in0), .in1(a_in1), .tag(a_tag), .kill(a_kill),
    .out_val(a_out_val), .out_rdy(a_out_rdy), .out(a_out), .out_tag(a_out_tag),
    .busy(a_busy)
  );

  vu_vxu_fu_imul_pipe #(.XLEN(32), .STAGES(1), .TAG_W(8)) dut_b (
    .clk(clk), .reset(reset), .val(b_val), .rdy(b_rdy), .fn(b_fn),
    .in0(b_in0), .in1(b_in1), .tag(b_tag), .kill(b_kill),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out(b_out), .out_tag(b_out_tag),
    .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference for XLEN=64 built from explicitly extended 128/64-bit products.
  function automatic logic [63:0] ref64(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  p32;
    logic [31:0]  r;
    case (f)
      4'd4: return a * b;
      4'd5: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      4'd6: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      4'd7: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      4'd0: begin r = a[31:0] * b[31:0]; return {{32{r[31]}}, r}; end
      4'd1: begin p32 = {{32{a[31]}}, a[31:0]} * {{32{b[31]}}, b[31:0]}; r = p32[63:32]; return {{32{r[31]}}, r}; end
      4'd2: begin p32 = {32'd0, a[31:0]} * {32'd0, b[31:0]};             r = p32[63:32]; return {{32{r[31]}}, r}; end
      4'd3: begin p32 = {{32{a[31]}}, a[31:0]} * {32'd0, b[31:0]};       r = p32[63:32]; return {{32{r[31]}}, r}; end
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [63:0] d;
    logic [7:0]  t;
  } exp_t;
  exp_t sbq[$];

  // One cycle of dut_a: sample handshakes mid-cycle, update scoreboard, advance to edge+1.
  task automatic cyc();
    exp_t e;
    #1;
    if (a_out_val && a_out_rdy) begin
      if (sbq.size() == 0) begin
        chk("spurious_result", 64'd1, 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_data", a_out, e.d);
        chk("sb_tag", {56'd0, a_out_tag}, {56'd0, e.t});
      end
    end
    if (a_kill) sbq.delete();
    else if (a_val && a_rdy) sbq.push_back('{ref64(a_fn, a_in0, a_in1), a_tag});
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    a_val     = 1'b0;
    a_out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0 && !a_busy) break;
      cyc();
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    chk("drain_idle", {63'd0, a_busy}, 64'd0);
  endtask

  typedef struct {
    logic [3:0]  fn;
    logic [63:0] in0;
    logic [63:0] in1;
    logic [7:0]  tag;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  fn;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] exp;
  } vecb_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs  [16];
    vecb_t vecsb [4];
    logic [63:0] held;
    int accepted, next_tag;
    logic acc;

    vecs[0]  = '{4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h11, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[1]  = '{4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h12, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{4'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h13, 64'h0000_0000_0000_0001};
    vecs[3]  = '{4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h14, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4]  = '{4'd0, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0002, 8'h21, 64'h0};
    vecs[5]  = '{4'd1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0002, 8'h22, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6]  = '{4'd2, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0002, 8'h23, 64'h1};
    vecs[7]  = '{4'd0, 64'hDEAD_BEEF_8000_0000, 64'hDEAD_BEEF_0000_0002, 8'h31, 64'h0};
    vecs[8]  = '{4'd1, 64'hDEAD_BEEF_8000_0000, 64'hDEAD_BEEF_0000_0002, 8'h32, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{4'd2, 64'hDEAD_BEEF_8000_0000, 64'hDEAD_BEEF_0000_0002, 8'h33, 64'h1};
    vecs[10] = '{4'd3, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 8'h34, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[11] = '{4'hF, 64'd5, 64'd7, 8'h41, 64'h0};
    vecs[12] = '{4'd0, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_8000, 8'h42, 64'hFFFF_FFFF_8000_0000};
    vecs[13] = '{4'd4, 64'h0000_0001_0000_0001, 64'd3, 8'h43, 64'h0000_0003_0000_0003};
    vecs[14] = '{4'd6, 64'h8000_0000_0000_0000, 64'd4, 8'h44, 64'h2};
    vecs[15] = '{4'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h45, 64'h8000_0000_0000_0000};

    vecsb[0] = '{4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecsb[1] = '{4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vecsb[2] = '{4'd0, 32'h0000_0003, 32'h0000_FFFF, 32'hFFFF_FFFD};
    vecsb[3] = '{4'hC, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000};

    reset = 1'b0;
    a_val = 0; a_fn = 0; a_in0 = 0; a_in1 = 0; a_tag = 0; a_kill = 0; a_out_rdy = 1;
    b_val = 0; b_fn = 0; b_in0 = 0; b_in1 = 0; b_tag = 0; b_kill = 0; b_out_rdy = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_val", {63'd0, a_out_val}, 64'd0);
    chk("reset_busy",    {63'd0, a_busy},    64'd0);
    chk("reset_rdy",     {63'd0, a_rdy},     64'd1);
    chk("reset_b_rdy",   {63'd0, b_rdy},     64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table on the 64-bit, 3-stage instance.
    for (int i = 0; i < 16; i++) begin
      a_fn = vecs[i].fn; a_in0 = vecs[i].in0; a_in1 = vecs[i].in1; a_tag = vecs[i].tag;
      a_val = 1'b1;
      chk("vec_rdy", {63'd0, a_rdy}, 64'd1);
      cyc();
      a_val = 1'b0;
      for (int s = 0; s < int'(STG_A) - 1; s++) begin
        chk("vec_early", {63'd0, a_out_val}, 64'd0);
        cyc();
      end
      chk("vec_latency", {63'd0, a_out_val}, 64'd1);
      chk($sformatf("vec%0d_out", i), a_out, vecs[i].exp);
      chk($sformatf("vec%0d_tag", i), {56'd0, a_out_tag}, {56'd0, vecs[i].tag});
      cyc();
    end
    drain_a();

    // Full throughput with out_rdy high.
    for (int i = 0; i < 8; i++) begin
      a_val = 1'b1; a_fn = 4'd4; a_in0 = 64'(i + 10); a_in1 = 64'd7; a_tag = 8'(8'h50 + i);
      chk("thru_rdy", {63'd0, a_rdy}, 64'd1);
      if (i >= int'(STG_A)) chk("thru_out_val", {63'd0, a_out_val}, 64'd1);
      cyc();
    end
    drain_a();

    // Backpressure: 5 back-to-back requests against a stalled output.
    a_out_rdy = 1'b0;
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      a_val = 1'b1; a_fn = 4'd4; a_in0 = 64'(accepted + 1); a_in1 = 64'd3; a_tag = 8'(accepted + 1);
      acc = a_rdy;
      cyc();
      if (acc) accepted++;
    end
    chk("bp_accepted", 64'(accepted), 64'd3);
    chk("bp_rdy_low", {63'd0, a_rdy}, 64'd0);
    held = a_out;
    repeat (2) cyc();
    chk("bp_stable_out", a_out, held);
    chk("bp_stable_tag", {56'd0, a_out_tag}, 64'd1);
    a_out_rdy = 1'b1;
    #1;
    chk("bp_rdy_same_cycle", {63'd0, a_rdy}, 64'd1);
    next_tag = 1;
    for (int c = 0; c < 20 && next_tag < 6; c++) begin
      if (accepted < 5) begin
        a_val = 1'b1; a_in0 = 64'(accepted + 1); a_tag = 8'(accepted + 1);
      end else begin
        a_val = 1'b0;
      end
      if (a_out_val) begin
        chk("bp_order", {56'd0, a_out_tag}, 64'(next_tag));
        next_tag++;
      end
      acc = a_val && a_rdy;
      cyc();
      if (acc) accepted++;
    end
    chk("bp_all_seen", 64'(next_tag), 64'd6);
    drain_a();

    // Bubble collapse: A, idle, B with output stalled.
    a_out_rdy = 1'b0; a_fn = 4'd4; a_in1 = 64'd5;
    a_val = 1'b1; a_in0 = 64'd1; a_tag = 8'hA1; cyc();
    a_val = 1'b0; cyc();
    a_val = 1'b1; a_in0 = 64'd2; a_tag = 8'hA2; cyc();
    a_val = 1'b0;
    chk("bub_a_out", {63'd0, a_out_val}, 64'd1);
    chk("bub_a_tag", {56'd0, a_out_tag}, 64'hA1);
    for (int c = 0; c < 2; c++) begin
      chk("bub_rdy_two", {63'd0, a_rdy}, 64'd1);
      cyc();
    end
    a_val = 1'b1; a_in0 = 64'd3; a_tag = 8'hA3;
    chk("bub_rdy_before_third", {63'd0, a_rdy}, 64'd1);
    cyc();
    a_val = 1'b0;
    chk("bub_full_rdy", {63'd0, a_rdy}, 64'd0);
    a_out_rdy = 1'b1;
    cyc();
    chk("bub_b_adjacent", {56'd0, a_out_tag}, 64'hA2);
    chk("bub_b_val", {63'd0, a_out_val}, 64'd1);
    cyc();
    chk("bub_c_adjacent", {56'd0, a_out_tag}, 64'hA3);
    cyc();
    chk("bub_done", {63'd0, a_out_val}, 64'd0);
    drain_a();

    // Kill with two ops in flight and a request on the kill cycle.
    a_out_rdy = 1'b0; a_fn = 4'd4; a_in1 = 64'd9;
    a_val = 1'b1; a_in0 = 64'd4; a_tag = 8'hB1; cyc();
    a_in0 = 64'd5; a_tag = 8'hB2; cyc();
    a_in0 = 64'd6; a_tag = 8'hB3; a_kill = 1'b1;
    chk("kill_rdy_ungated", {63'd0, a_rdy}, 64'd1);
    cyc();
    a_kill = 1'b0; a_val = 1'b0;
    chk("kill_busy", {63'd0, a_busy}, 64'd0);
    chk("kill_out_val", {63'd0, a_out_val}, 64'd0);
    a_out_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("kill_no_result", {63'd0, a_out_val}, 64'd0);
      cyc();
    end

    // Asynchronous reset mid-operation.
    a_out_rdy = 1'b0;
    a_val = 1'b1; a_in0 = 64'd7; a_tag = 8'hC1; cyc();
    a_val = 1'b0; cyc(); cyc();
    chk("arst_pre_val", {63'd0, a_out_val}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_val", {63'd0, a_out_val}, 64'd0);
    chk("arst_busy", {63'd0, a_busy}, 64'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      a_val = ($urandom_range(0, 3) != 0);
      a_fn  = 4'($urandom_range(0, 9));
      a_in0 = {$urandom, $urandom};
      a_in1 = {$urandom, $urandom};
      a_tag = 8'($urandom);
      a_kill = ($urandom_range(0, 63) == 0);
      a_out_rdy = a_kill ? 1'b0 : ($urandom_range(0, 3) != 0);
      cyc();
    end
    a_kill = 1'b0;
    drain_a();

    // 32-bit, single-stage instance.
    for (int i = 0; i < 4; i++) begin
      b_fn = vecsb[i].fn; b_in0 = vecsb[i].in0; b_in1 = vecsb[i].in1; b_tag = 8'(8'hD0 + i);
      b_val = 1'b1;
      chk("b_rdy", {63'd0, b_rdy}, 64'd1);
      @(posedge clk); #1;
      b_val = 1'b0;
      chk("b_out_val", {63'd0, b_out_val}, 64'd1);
      chk($sformatf("b_vec%0d_out", i), {32'd0, b_out}, {32'd0, vecsb[i].exp});
      chk("b_tag", {56'd0, b_out_tag}, 64'(8'hD0 + i));
      @(posedge clk); #1;
      chk("b_retired", {63'd0, b_out_val}, 64'd0);
    end
    b_out_rdy = 1'b0; b_val = 1'b1; b_fn = 4'd5; b_tag = 8'hE1;
    @(posedge clk); #1;
    chk("b_full_rdy", {63'd0, b_rdy}, 64'd0);
    b_tag = 8'hE2;
    b_out_rdy = 1'b1;
    #1;
    chk("b_rdy_same_cycle", {63'd0, b_rdy}, 64'd1);
    @(posedge clk); #1;
    b_val = 1'b0;
    chk("b_refill_val", {63'd0, b_out_val}, 64'd1);
    chk("b_refill_tag", {56'd0, b_out_tag}, 64'hE2);
    @(posedge clk); #1;
    chk("b_drained", {63'd0, b_busy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
